// File: rtl/uart_pkg.sv
// Shared UART definitions: shifter state encoding, default timing and frame constants.
// Both the transmitter and the receiver import this package.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam int unsigned DEFAULT_STOP_BITS    = 1;
  localparam int unsigned DATA_BITS            = 8;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  // Cycles from the falling edge of the start bit to the end of the last stop bit.
  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                               input int unsigned stop_bits);
    return (1 + DATA_BITS + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Restartable per-bit cycle counter: counts 0..CLKS_PER_BIT-1 while enabled and wraps at each
// bit boundary; bit_end flags the last cycle of a bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            enable,
  output logic [$clog2(CLKS_PER_BIT)-1:0] count,
  output logic                            bit_end
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCount = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] count_q, count_d;

  assign bit_end = (count_q == LastCount);
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = bit_end ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-deep holding register feeding an 8N1/8N2 shifter, with registered line,
// busy and done outputs so frames can be streamed back-to-back.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = DEFAULT_STOP_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] PreEndCount = CntW'(CLKS_PER_BIT - 2);
  localparam logic [2:0] LastIdx  = 3'(DATA_BITS - 1);
  localparam logic       StopLast = 1'(STOP_BITS - 1);

  uart_state_e     state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic            stop_idx_q, stop_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_data_q, hold_data_d;
  logic            hold_full_q, hold_full_d;
  logic            ready_q, ready_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept;
  logic            load;
  logic            timer_clear;
  logic            timer_en;
  logic            bit_end;
  logic [CntW-1:0] count;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .count  (count),
    .bit_end(bit_end)
  );

  assign accept = tx_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stop_idx_d  = stop_idx_q;
    load        = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b1;
    unique case (state_q)
      IDLE: begin
        timer_clear = 1'b1;
        timer_en    = 1'b0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LastIdx) begin
            state_d    = STOP;
            stop_idx_d = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_idx_q == StopLast) begin
            stop_idx_d = 1'b0;
            // A byte already waiting goes straight into the next start bit.
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load and accept never coincide: accept needs ready, which is low whenever the hold is full.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    if (load) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
    end
    shift_d = load ? hold_data_q : shift_q;
    ready_d = !hold_full_d;
  end

  // Outputs are computed from next state so the registered values line up with the FSM.
  always_comb begin
    tx_d = IDLE_LEVEL;
    unique case (state_d)
      IDLE:    tx_d = IDLE_LEVEL;
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shift_d[idx_d];
      STOP:    tx_d = STOP_LEVEL;
      default: tx_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (stop_idx_q == StopLast) && (count == PreEndCount);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      tx_q        <= IDLE_LEVEL;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx_ready = ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a line decoder pops a scoreboard of accepted bytes, plus
// cycle-exact waveform checks for 8N1 and 8N2 frames.
module tb_uart_tx;

  localparam int C = 16;

  logic       clk;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       done;

  logic       v2;
  logic [7:0] d2;
  logic       r2;
  logic       tx2;
  logic       busy2;
  logic       done2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] sb[$];
  int start_log[$];
  int done_log[$];

  uart_tx #(
    .CLKS_PER_BIT(C),
    .STOP_BITS   (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  uart_tx #(
    .CLKS_PER_BIT(C),
    .STOP_BITS   (2)
  ) dut2 (
    .clk     (clk),
    .reset   (reset),
    .tx_valid(v2),
    .tx_data (d2),
    .tx_ready(r2),
    .tx      (tx2),
    .busy    (busy2),
    .done    (done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic exp_tx(input logic [7:0] b, input int c);
    if (c >= 1 && c <= C) return 1'b0;
    if (c > C && c <= 9 * C) return b[(c - C - 1) / C];
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int c, input int s);
    return (c >= 1) && (c <= (9 + s) * C);
  endfunction

  // Line decoder on the STOP_BITS=1 instance; samples mid-bit and pops the scoreboard.
  initial begin : monitor
    bit         active;
    int         pos;
    logic [7:0] rx_byte;
    logic [7:0] exp_byte;
    active  = 1'b0;
    pos     = 0;
    rx_byte = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          pos    = 0;
          start_log.push_back(cyc);
        end
      end else begin
        pos++;
      end
      if (active && !reset) begin
        if (pos == C / 2) begin
          check("start_bit", tx, 1'b0);
        end else if ((pos % C) == C / 2 && pos / C >= 1 && pos / C <= 8) begin
          rx_byte[pos / C - 1] = tx;
        end else if (pos == 9 * C + C / 2) begin
          check("stop_bit", tx, 1'b1);
          check("sb_nonempty", sb.size() != 0, 1'b1);
          exp_byte = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
          check("rx_byte", rx_byte, exp_byte);
          active = 1'b0;
        end
      end
      if (!reset && done === 1'b1) done_log.push_back(cyc);
    end
  end

  // Returns on the negedge following the accepting edge (relative cycle 0).
  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept", tx_ready, 1'b1);
    sb.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || busy !== 1'b0) && n < 3000);
    repeat (4) @(negedge clk);
    check("drain", (sb.size() == 0) && (busy === 1'b0), 1'b1);
  endtask

  task automatic wave_check(input int sel, input logic [7:0] b, input int s, input int last);
    logic o_tx, o_busy, o_done, o_ready;
    for (int c = 0; c <= last; c++) begin
      o_tx    = sel ? tx2 : tx;
      o_busy  = sel ? busy2 : busy;
      o_done  = sel ? done2 : done;
      o_ready = sel ? r2 : tx_ready;
      check("wave_tx", o_tx, exp_tx(b, c));
      check("wave_busy", o_busy, exp_busy(c, s));
      check("wave_done", o_done, c == (9 + s) * C);
      check("wave_ready", o_ready, c >= 1);
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    int n0;
    int d0;
    bit toggle;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    v2       = 1'b0;
    d2       = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_tx2", tx2, 1'b1);
    check("rst_ready2", r2, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_tx", tx, 1'b1);

    // Single 8N1 frame, cycle exact.
    push_byte(8'h55);
    wave_check(0, 8'h55, 1, 170);
    wait_drain();

    // Back-to-back frames with no idle gap.
    start_log.delete();
    done_log.delete();
    push_byte(8'hA3);
    k = cyc;
    push_byte(8'h0F);
    wait_drain();
    check("b2b_starts", start_log.size(), 2);
    check("b2b_dones", done_log.size(), 2);
    if (start_log.size() >= 2 && done_log.size() >= 2) begin
      check("b2b_start0", start_log[0], k + 1);
      check("b2b_start1", start_log[1], k + 161);
      check("b2b_done0", done_log[0], k + 160);
      check("b2b_done1", done_log[1], k + 320);
    end

    // 8N2 frame on the second instance.
    @(negedge clk);
    check("t3_ready", r2, 1'b1);
    v2 = 1'b1;
    d2 = 8'hFF;
    @(negedge clk);
    v2 = 1'b0;
    wave_check(1, 8'hFF, 2, 185);

    // Reset during data bit 3 with a second byte held.
    push_byte(8'hC6);
    push_byte(8'h99);
    repeat (68) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", tx_ready, 1'b1);
    check("mid_rst_done", done, 1'b0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    n0 = start_log.size();
    d0 = done_log.size();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("post_rst_tx", tx, 1'b1);
      check("post_rst_busy", busy, 1'b0);
    end
    check("post_rst_frames", start_log.size(), n0);
    check("post_rst_done", done_log.size(), d0);
    push_byte(8'h3C);
    wait_drain();
    check("after_rst_frame", start_log.size(), n0 + 1);

    // Data stability and ignored valid while not ready.
    start_log.delete();
    push_byte(8'h81);
    push_byte(8'h5A);
    toggle = 1'b0;
    for (int i = 0; i < 1000 && !tx_ready; i++) begin
      tx_valid = 1'b1;
      tx_data  = toggle ? 8'h00 : 8'($urandom);
      toggle   = !toggle;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tx_data = 8'($urandom);
      @(negedge clk);
    end
    wait_drain();
    check("stab_frames", start_log.size(), 2);

    // Stream of every byte value, back-to-back.
    start_log.delete();
    done_log.delete();
    for (int i = 0; i < 256; i++) begin
      push_byte(8'(i));
    end
    wait_drain();
    check("stream_starts", start_log.size(), 256);
    check("stream_dones", done_log.size(), 256);
    if (start_log.size() == 256 && done_log.size() == 256) begin
      for (int i = 0; i < 255; i++) begin
        check("stream_gap", start_log[i + 1] - start_log[i], 10 * C);
      end
      check("stream_span", done_log[255] - start_log[0], 256 * 10 * C - 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
